led_anim_multi: RTL and testbench

- Parametrised successor to the single-channel walking-light animator.
- Drives an N_LED-wide LED bank with four selectable animation modes, a programmable step period and PWM brightness on the lit LEDs.
- Sits between board-level LED pins and the control register block.
- Registered outputs; the output is forced low (never X) when disabled.

---
 rtl/led_anim_pkg.sv | 21 ++
 rtl/led_anim_multi_pwm.sv | 37 +++
 rtl/led_anim_multi.sv | 177 +++++++++++++++++
 tb/tb_led_anim_multi.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/led_anim_pkg.sv
// Shared encodings and helpers for the multi-channel LED animator.
package led_anim_pkg;

  typedef enum logic [1:0] {
    MODE_WALK_L = 2'd0,
    MODE_WALK_R = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Direction a freshly (re)started animation begins with.
  function automatic dir_e start_dir(input mode_e m);
    return (m == MODE_WALK_R) ? DIR_DOWN : DIR_UP;
  endfunction

endpackage

// File: rtl/led_anim_multi_pwm.sv
// Free-running PWM counter with duty compare; optional second compare for the trail
// (extra ports present only when LED_ANIM_TRAIL_EN is defined).
module led_pwm_gen #(
  parameter int unsigned PWM_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PWM_W-1:0] duty,
`ifdef LED_ANIM_TRAIL_EN
  input  logic [PWM_W-1:0] aux_duty,
  output logic             aux_on_c,
`endif
  output logic             pwm_on_c
);

  localparam logic [PWM_W-1:0] DUTY_FULL = {PWM_W{1'b1}};

  logic [PWM_W-1:0] cnt_q;

  // Counter wraps naturally at 2^PWM_W and freezes while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + PWM_W'(1);
    end
  end

  // All-ones duty is fully on rather than (2^PWM_W-1)/2^PWM_W.
  assign pwm_on_c = (duty == DUTY_FULL) | (cnt_q < duty);

`ifdef LED_ANIM_TRAIL_EN
  assign aux_on_c = (cnt_q < aux_duty);
`endif

endmodule

// File: rtl/led_anim_multi.sv
// N_LED-wide LED animator: walk left/right, bounce and fill with PWM brightness.
// Define LED_ANIM_TRAIL_EN to light the previous position at half brightness.
module led_anim_multi
  import led_anim_pkg::*;
#(
  parameter int unsigned N_LED  = 8,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned PWM_W  = 4,
  parameter int unsigned POS_W  = $clog2(N_LED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step_div,
  input  logic [PWM_W-1:0]  duty,
  output logic [N_LED-1:0]  out,
  output logic [POS_W-1:0]  pos,
  output logic              step_pulse
);

  localparam int unsigned      LAST_IDX = N_LED - 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(LAST_IDX);

  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              tick_c;
  logic [POS_W-1:0]  pos_d;
  dir_e              dir_q, dir_d;
  mode_e             mode_q, mode_d;
  mode_e             mode_in;
  logic              step_pulse_d;
  logic [N_LED-1:0]  mask_c;
  logic [N_LED-1:0]  out_d;
  logic              pwm_on_c;

`ifdef LED_ANIM_TRAIL_EN
  logic [POS_W-1:0]  prev_q, prev_d;
  logic [N_LED-1:0]  trail_c;
  logic              trail_on_c;
`endif

  assign mode_in = mode_e'(mode);

  led_pwm_gen #(
    .PWM_W (PWM_W)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .duty     (duty),
`ifdef LED_ANIM_TRAIL_EN
    .aux_duty (duty >> 1),
    .aux_on_c (trail_on_c),
`endif
    .pwm_on_c (pwm_on_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      pos        <= '0;
      dir_q      <= DIR_UP;
      mode_q     <= MODE_WALK_L;
      step_pulse <= 1'b0;
      out        <= '0;
`ifdef LED_ANIM_TRAIL_EN
      prev_q     <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      pos        <= pos_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      step_pulse <= step_pulse_d;
      out        <= out_d;
`ifdef LED_ANIM_TRAIL_EN
      prev_q     <= prev_d;
`endif
    end
  end

  // Prescaler and step sequencing.
  always_comb begin
    cnt_d        = cnt_q;
    tick_c       = 1'b0;
    pos_d        = pos;
    dir_d        = dir_q;
    mode_d       = mode_q;
    step_pulse_d = 1'b0;
`ifdef LED_ANIM_TRAIL_EN
    prev_d       = prev_q;
`endif

    if (en) begin
      if (cnt_q == step_div) begin
        cnt_d  = '0;
        tick_c = 1'b1;
      end else if (cnt_q > step_div) begin
        // step_div shrank below the running count: restart silently.
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + STEP_W'(1);
      end
    end

    if (tick_c) begin
      step_pulse_d = 1'b1;
      if (mode_in != mode_q) begin
        mode_d = mode_in;
        pos_d  = (mode_in == MODE_WALK_R) ? LAST_POS : '0;
        dir_d  = start_dir(mode_in);
`ifdef LED_ANIM_TRAIL_EN
        prev_d = pos_d;
`endif
      end else begin
`ifdef LED_ANIM_TRAIL_EN
        prev_d = pos;
`endif
        unique case (mode_q)
          MODE_WALK_R: begin
            pos_d = (pos == '0) ? LAST_POS : pos - POS_W'(1);
          end
          MODE_BOUNCE: begin
            // Reversal happens on the step after reaching an end, so ends are held once.
            if (dir_q == DIR_UP) begin
              if (pos == LAST_POS) begin
                dir_d = DIR_DOWN;
                pos_d = LAST_POS - POS_W'(1);
              end else begin
                pos_d = pos + POS_W'(1);
              end
            end else begin
              if (pos == '0) begin
                dir_d = DIR_UP;
                pos_d = POS_W'(1);
              end else begin
                pos_d = pos - POS_W'(1);
              end
            end
          end
          default: begin
            pos_d = (pos == LAST_POS) ? '0 : pos + POS_W'(1);
          end
        endcase
      end
    end
  end

  // Lit-LED mask: one-hot for the moving modes, thermometer for FILL.
  always_comb begin
    mask_c = '0;
    if (mode_q == MODE_FILL) begin
      for (int i = 0; i < int'(N_LED); i++) begin
        mask_c[i] = (POS_W'(i) <= pos);
      end
    end else begin
      mask_c[pos] = 1'b1;
    end
  end

`ifdef LED_ANIM_TRAIL_EN
  // Trail only after a real advance; prev equals pos after reset or restart.
  always_comb begin
    trail_c = '0;
    if ((mode_q != MODE_FILL) && (prev_q != pos)) begin
      trail_c[prev_q] = 1'b1;
    end
  end

  assign out_d = en ? ((mask_c & {N_LED{pwm_on_c}}) | (trail_c & {N_LED{trail_on_c}}))
                    : '0;
`else
  assign out_d = en ? (mask_c & {N_LED{pwm_on_c}}) : '0;
`endif

endmodule

// File: tb/tb_led_anim_multi.sv
// Directed self-checking bench for led_anim_multi with a step scoreboard.
module tb_led_anim_multi;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] step_div;
  logic [3:0]  duty;
  logic [7:0]  out;
  logic [2:0]  pos;
  logic        step_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] pos;
    logic [7:0] out;
  } exp_t;

  exp_t sb[$];

  led_anim_multi dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .step_div   (step_div),
    .duty       (duty),
    .out        (out),
    .pos        (pos),
    .step_pulse (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int p, input int o);
    exp_t e;
    e.pos = 3'(p);
    e.out = 8'(o);
    sb.push_back(e);
  endtask

  // Consume the scoreboard: pos at each step_pulse, out one cycle later.
  task automatic run_steps(input string tag, input int gap);
    bit         pend;
    logic [7:0] pend_out;
    int         cyc;
    int         k;
    exp_t       e;
    pend = 1'b0;
    pend_out = '0;
    k = 0;
    while (sb.size() > 0) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (pend) begin
          check({tag, " out"}, 32'(out), 32'(pend_out));
          pend = 1'b0;
        end
      end while (!step_pulse && cyc < 40);
      if (!step_pulse) begin
        check({tag, " step_pulse timeout"}, 32'(step_pulse), 32'd1);
        sb.delete();
        return;
      end
      e = sb.pop_front();
      check({tag, " pos"}, 32'(pos), 32'(e.pos));
      if (k > 0 && gap > 0) check({tag, " step gap"}, 32'(cyc), 32'(gap));
      pend_out = e.out;
      pend = 1'b1;
      k++;
    end
    @(negedge clk);
    if (pend) check({tag, " out"}, 32'(out), 32'(pend_out));
  endtask

  // Count cycles with the static lit LED high over one PWM period.
  task automatic pwm_count(input string tag, input logic [3:0] d, input int exp_hi);
    int hi;
    duty = d;
    hi = 0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (out[0] === 1'b1) hi++;
    end
    check(tag, 32'(hi), 32'(exp_hi));
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    mode     = 2'd0;
    step_div = 16'd3;
    duty     = 4'd15;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("reset out", 32'(out), 32'h0);
    check("reset pos", 32'(pos), 32'h0);
    check("reset step_pulse", 32'(step_pulse), 32'h0);

    // WALK_L from reset, step every 4 cycles.
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    check("walk_l initial out", 32'(out), 32'h01);
    for (int p = 1; p <= 7; p++) push(p, 1 << p);
    push(0, 8'h01);
    run_steps("walk_l", 4);

    // Walk on to pos 3, then switch to WALK_R.
    for (int p = 1; p <= 3; p++) push(p, 1 << p);
    run_steps("walk_l to 3", 4);
    mode = 2'd1;
    for (int p = 7; p >= 0; p--) push(p, 1 << p);
    push(7, 8'h80);
    run_steps("walk_r", 4);

    // BOUNCE at one step per cycle.
    mode     = 2'd2;
    step_div = 16'd0;
    for (int p = 0; p <= 7; p++) push(p, 1 << p);
    for (int p = 6; p >= 0; p--) push(p, 1 << p);
    push(1, 8'h02);
    run_steps("bounce", 1);

    // FILL every 2 cycles.
    mode     = 2'd3;
    step_div = 16'd1;
    for (int p = 0; p <= 7; p++) push(p, (1 << (p + 1)) - 1);
    push(0, 8'h01);
    run_steps("fill", 2);

    // PWM on a static lit LED (FILL pos 0 lights bit 0).
    step_div = 16'hFFFF;
    pwm_count("pwm duty4", 4'd4, 4);
    pwm_count("pwm duty0", 4'd0, 0);
    pwm_count("pwm duty15", 4'd15, 16);
    pwm_count("pwm duty8", 4'd8, 8);
    check("pwm pos static", 32'(pos), 32'h0);

    // Walk to pos 5, then disable for 20 cycles with mode glitches.
    mode     = 2'd0;
    step_div = 16'd3;
    duty     = 4'd15;
    for (int p = 0; p <= 5; p++) push(p, 1 << p);
    run_steps("walk to 5", 4);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("en0 out", 32'(out), 32'h0);
      check("en0 pos", 32'(pos), 32'h5);
      check("en0 step_pulse", 32'(step_pulse), 32'h0);
      if (i == 5) mode = 2'd1;
      if (i == 10) mode = 2'd0;
    end
    en = 1'b1;
    push(6, 8'h40);
    push(7, 8'h80);
    push(0, 8'h01);
    push(1, 8'h02);
    run_steps("resume", 4);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check("async rst out", 32'(out), 32'h0);
    check("async rst pos", 32'(pos), 32'h0);
    check("async rst step_pulse", 32'(step_pulse), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
